// File: rtl/nv_nvdla_dma_pipe_pkg.sv
// Shared constants and width helpers for the DMA read-response pipe.
package nv_nvdla_dma_pipe_pkg;

  localparam int unsigned DMA_RSP_PD_W = 514;
  localparam int unsigned MAX_STAGES   = 4;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = 32'(i + 1);
    end
    return res;
  endfunction

  // Occupancy counter width: enough for 2*stages beats, at least one bit.
  function automatic int unsigned occ_width(input int unsigned stages);
    return (stages == 0) ? 1 : clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/nv_nvdla_dma_rsp_skid_stage.sv
// One full-throughput 2-entry skid stage: registered input ready, head register
// drives the output directly, synchronous flush drops both entries.
module nv_nvdla_dma_rsp_skid_stage
  import nv_nvdla_dma_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_RSP_PD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_pd_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_pd_o,
  input  logic              out_ready_i,
  output logic [1:0]        count_o
);

  logic [1:0]        count_q, count_d;
  logic              rdy_q;
  logic [DATA_W-1:0] head_q, skid_q;
  logic              push, pop;

  assign in_ready_o  = rdy_q & ~flush_i;
  assign out_valid_o = (count_q != 2'd0) & ~flush_i;
  assign out_pd_o    = head_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  // Next-state count, so a registered sum matches the counts after the edge.
  assign count_o     = count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      rdy_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      rdy_q   <= (count_d < 2'd2);
    end
  end

  // Payload registers carry no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push && ((count_q == 2'd0) || pop)) begin
      head_q <= in_pd_i;
    end else if (pop && (count_q == 2'd2)) begin
      head_q <= skid_q;
    end
    if (push && !pop && (count_q == 2'd1)) begin
      skid_q <= in_pd_i;
    end
  end

endmodule

// File: rtl/nv_nvdla_dma_rsp_pipe.sv
// Parametrised valid/ready pipe for DMA read-response beats: STAGES chained skid
// stages (or a wire passthrough for STAGES=0) with flush, occupancy and idle.
module nv_nvdla_dma_rsp_pipe
  import nv_nvdla_dma_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_RSP_PD_W,
  parameter int unsigned STAGES = 1,
  parameter int unsigned OCC_W  = occ_width(STAGES)
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              rsp_flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pd,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pd,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic              idle
);

  assign idle = (occupancy == '0) & ~in_valid;

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = nvdla_core_clk ^ nvdla_core_rstn;

    assign in_ready  = out_ready & ~rsp_flush;
    assign out_valid = in_valid & ~rsp_flush;
    assign out_pd    = in_pd;
    assign occupancy = '0;
  end else begin : g_pipe
    logic [STAGES:0]   vld, rdy;
    logic [DATA_W-1:0] pd      [STAGES+1];
    logic [1:0]        cnt_nxt [STAGES];
    logic [OCC_W-1:0]  occ_d, occ_q;

    assign vld[0]      = in_valid;
    assign pd[0]       = in_pd;
    assign in_ready    = rdy[0];
    assign out_valid   = vld[STAGES];
    assign out_pd      = pd[STAGES];
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      nv_nvdla_dma_rsp_skid_stage #(
        .DATA_W (DATA_W)
      ) u_stage (
        .clk_i       (nvdla_core_clk),
        .rst_ni      (nvdla_core_rstn),
        .flush_i     (rsp_flush),
        .in_valid_i  (vld[k]),
        .in_pd_i     (pd[k]),
        .in_ready_o  (rdy[k]),
        .out_valid_o (vld[k+1]),
        .out_pd_o    (pd[k+1]),
        .out_ready_i (rdy[k+1]),
        .count_o     (cnt_nxt[k])
      );
    end

    always_comb begin
      occ_d = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        occ_d = occ_d + OCC_W'(cnt_nxt[k]);
      end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_d;
      end
    end

    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_nv_nvdla_dma_rsp_pipe.sv
// Scoreboard bench: a 2-stage pipe checked against a beat queue, plus a
// STAGES=0 instance checked as pure wires on the same inputs.
module tb_nv_nvdla_dma_rsp_pipe;

  localparam int unsigned ST  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned OW  = 3;
  localparam int unsigned CAP = 2 * ST;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_pd = '0;

  logic          in_ready, out_valid, idle;
  logic [DW-1:0] out_pd;
  logic [OW-1:0] occupancy;
  logic          in_ready0, out_valid0, idle0;
  logic [DW-1:0] out_pd0;
  logic [0:0]    occupancy0;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  bit            in_fire = 1'b0;
  bit            out_fire = 1'b0;
  int            n_out = 0;
  int            nxt, acc, base, cyc, sent;
  bit            flag;

  always #5 clk = ~clk;

  nv_nvdla_dma_rsp_pipe #(.DATA_W(DW), .STAGES(ST)) u_dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .rsp_flush       (flush),
    .in_valid        (in_valid),
    .in_pd           (in_pd),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_pd          (out_pd),
    .out_ready       (out_ready),
    .occupancy       (occupancy),
    .idle            (idle)
  );

  nv_nvdla_dma_rsp_pipe #(.DATA_W(DW), .STAGES(0)) u_dut0 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .rsp_flush       (flush),
    .in_valid        (in_valid),
    .in_pd           (in_pd),
    .in_ready        (in_ready0),
    .out_valid       (out_valid0),
    .out_pd          (out_pd0),
    .out_ready       (out_ready),
    .occupancy       (occupancy0),
    .idle            (idle0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle sampling, model queue holds every beat inside the pipe.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      in_fire  = 1'b0;
      out_fire = 1'b0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("idle", 64'(idle), 64'((exp_q.size() == 0) && !in_valid));
      if (flush) begin
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
      end else if (exp_q.size() == 0) begin
        chk("empty_in_ready", 64'(in_ready), 64'(1));
        chk("empty_out_valid", 64'(out_valid), 64'(0));
      end
      out_fire = out_valid && out_ready;
      in_fire  = in_valid && in_ready;
      if (out_fire) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_pd: got 0x%0h expected no beat at %0t", out_pd, $time);
        end else begin
          chk("out_pd", 64'(out_pd), 64'(exp_q.pop_front()));
        end
      end
      if (flush) exp_q.delete();
      if (in_fire) exp_q.push_back(in_pd);
    end
    chk("byp_out_valid", 64'(out_valid0), 64'(in_valid && !flush));
    chk("byp_in_ready", 64'(in_ready0), 64'(out_ready && !flush));
    chk("byp_out_pd", 64'(out_pd0), 64'(in_pd));
    chk("byp_occupancy", 64'(occupancy0), 64'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input string name, input int n);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && acc < n; i++) begin
      in_pd = DW'($urandom);
      step();
      if (in_fire) acc++;
    end
    in_valid = 1'b0;
    chk({name, "_pushed"}, 64'(acc), 64'(n));
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk({name, "_drained_occ"}, 64'(occupancy), 64'(0));
  endtask

  task automatic latency_test(input string name, input logic [DW-1:0] val);
    int lat;
    bit seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pd     = val;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (in_fire) seen = 1'b1;
    end
    chk({name, "_accept"}, 64'(seen), 64'(1));
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = i;
        chk({name, "_pd"}, 64'(out_pd), 64'(val));
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(ST));
    step();
    chk({name, "_occ_back"}, 64'(occupancy), 64'(0));
  endtask

  // Advance the 1..6 fill sequence on each accepted beat.
  task automatic fill_step();
    step();
    if (in_fire) begin
      acc++;
      nxt++;
      if (nxt > 6) in_valid = 1'b0;
      else in_pd = DW'(nxt);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    in_valid = 1'b1;
    #1;
    chk("rst_idle_in_valid", 64'(idle), 64'(0));
    in_valid = 1'b0;
    rstn = 1'b1;
    step();

    latency_test("latency", 32'hA5);

    // Fill with downstream stalled, then stream out in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    nxt = 1;
    in_pd = DW'(nxt);
    acc = 0;
    for (int i = 0; i < 10; i++) fill_step();
    chk("fill_accepted", 64'(acc), 64'(CAP));
    chk("fill_in_ready", 64'(in_ready), 64'(0));
    chk("fill_occupancy", 64'(occupancy), 64'(CAP));
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 6; i++) fill_step();
    chk("fill_no_gaps", 64'(n_out - base), 64'(6));
    chk("fill_all_accepted", 64'(acc), 64'(6));
    drain("fill");

    // Throughput: both sides always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pd = DW'($urandom);
    base = n_out;
    sent = 0;
    cyc  = 0;
    flag = 1'b0;
    while ((n_out - base) < 100 && cyc < 300) begin
      step();
      cyc++;
      if (in_fire) begin
        sent++;
        if (sent == 100) in_valid = 1'b0;
        else in_pd = DW'($urandom);
      end
      if (in_valid && !in_ready) flag = 1'b1;
    end
    chk("thru_received", 64'(n_out - base), 64'(100));
    chk("thru_cycles_ok", 64'(cyc <= int'(100 + ST)), 64'(1));
    chk("thru_in_ready_held", 64'(flag), 64'(0));
    drain("thru");

    // Flush with three beats buffered.
    push_n("flush", 3);
    chk("flush_pre_occ", 64'(occupancy), 64'(3));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pd    = 32'h99;
    @(negedge clk);
    chk("flush_cyc_in_ready", 64'(in_ready), 64'(0));
    chk("flush_cyc_out_valid", 64'(out_valid), 64'(0));
    step();
    flush = 1'b0;
    #1;
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_idle_busy", 64'(idle), 64'(0));
    in_valid = 1'b0;
    #1;
    chk("flush_idle", 64'(idle), 64'(1));
    latency_test("flush_lat", 32'h5A);

    // Reset asserted with two beats buffered.
    push_n("rstmid", 2);
    chk("rstmid_pre_occ", 64'(occupancy), 64'(2));
    rstn = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'(0));
    chk("rstmid_occ", 64'(occupancy), 64'(0));
    exp_q.delete();
    step();
    step();
    rstn = 1'b1;
    #1;
    chk("rstmid_in_ready", 64'(in_ready), 64'(1));
    step();

    // Random stall with occasional flush.
    flag = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) == 0);
      in_pd     = DW'($urandom);
      step();
      if (occupancy > OW'(CAP)) flag = 1'b1;
    end
    flush = 1'b0;
    chk("rand_occ_bound", 64'(flag), 64'(0));
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nv_nvdla_dma_rsp_pipe.md
# nv_nvdla_dma_rsp_pipe

Parametrised valid/ready pipeline for DMA read-response payloads. It sits between the memory-client read-response mux and the DMA consumer inside a CDMA sub-unit, for example weight or feature fetch. It chains STAGES full-throughput skid stages, each with a registered input ready, so that timing is cut in both the forward and backward directions. Compared with the single fixed-width skid pipe it adds:
- configurable width and depth;
- a synchronous flush;
- occupancy and idle status outputs.

## Interface
- DATA_W, default 514: payload width in bits.
- STAGES, default 1: number of skid stages, legal range 0..4. With STAGES=0 the block is a combinational passthrough.
- OCC_W, default derived: clog2(2*STAGES+1), minimum 1. Width of `occupancy`.
- nvdla_core_clk, input, 1: the single clock. All state is on its rising edge.
- nvdla_core_rstn, input, 1: reset, asynchronous and active-low.
- rsp_flush, input, 1: synchronous flush. Discards every buffered beat.
- in_valid, input, 1: upstream beat valid.
- in_pd, input, DATA_W: upstream payload.
- in_ready, output, 1: upstream may transfer this cycle.
- out_valid, output, 1: downstream beat valid.
- out_pd, output, DATA_W: downstream payload.
- out_ready, input, 1: downstream accepts.
- occupancy, output, OCC_W: beats held across all stages. Registered.
- idle, output, 1: high when occupancy==0 and in_valid==0.

## Operation
- Each stage is a 2-entry FIFO with entries head and skid, and a count of 0..2.
- Stage push = s_in_valid & s_in_ready. Stage pop = s_out_valid & s_out_ready.
- s_out_valid = (count!=0) & !rsp_flush. s_out_pd = head. The head register drives the output directly, with no mux on the data path.
- s_in_ready = rdy_q & !rsp_flush. On each clock edge, rdy_q takes the value (count_next < 2). Ready is never combinational from out_ready.
- Count transitions:
  - push only: +1;
  - pop only: -1;
  - push and pop together: unchanged;
  - a push when count==2 cannot occur because rdy_q is 0.
- Entry movement:
  - push into count 0 writes head;
  - push into count 1 with no pop writes skid;
  - pop with count 2 moves skid to head;
  - push and pop together at count 1 writes head with the new beat.
- Stages chain as out of stage k to in of stage k+1. The block ports connect to stage 0 input and stage STAGES-1 output.
- Ordering is strict FIFO. No beat is dropped or duplicated, except on flush.
- Flush: while rsp_flush=1, in_ready=0 and out_valid=0, so no transfer occurs on either side. At the next edge every count becomes 0 and rdy_q becomes 1. Payload registers are not cleared.
- occupancy is registered and equals the sum of the stage counts after each edge.
- STAGES=0: in_ready=out_ready, out_valid=in_valid, out_pd=in_pd, occupancy=0. rsp_flush still gates in_ready and out_valid.

## Timing
- Reset values:
  - in_ready=1 (for STAGES≥1);
  - out_valid=0;
  - occupancy=0;
  - idle reflects in_valid;
  - out_pd is don't-care, because data registers have no reset.
- Latency: a beat accepted at edge N is first presented on out_valid in cycle N+STAGES, provided the path is empty.
- Throughput: 1 beat per cycle in steady state with out_ready=1.
- Backpressure: after out_ready falls, in_ready falls within STAGES cycles. Up to 2*STAGES beats are absorbed, and none are lost.
- Recovery: a stage at count 2 that pops at edge N has s_in_ready=1 in cycle N+1.
- Reset asserted mid-transfer clears all counts immediately. Buffered beats are lost, and in_ready returns to 1 on the first edge-free cycle after rstn deassertion.
- Flush and reset together: reset dominates.

## Structure
- Package nv_nvdla_dma_pipe_pkg holds:
  - the localparam DMA_RSP_PD_W=514;
  - the MAX_STAGES=4 constant;
  - a clog2 helper function.
- Sub-module nv_nvdla_dma_rsp_skid_stage (params DATA_W) implements one 2-entry stage with count and rdy_q, and exposes its count.
- The top level instantiates STAGES copies of the stage with a generate loop. It also contains the STAGES=0 bypass, the occupancy adder register and the idle logic.

## Test plan
- Latency: STAGES=3, out_ready=1, single beat 0xA5 accepted at edge 10 -> out_valid=1 with out_pd=0xA5 in cycle 13; occupancy reaches 1, then returns to 0.
- Fill: STAGES=2, out_ready=0, in_valid held with beats 1..6 -> exactly 4 beats accepted; in_ready=0 and occupancy=4. Then set out_ready=1 -> output is 1,2,3,4,5,6 in order, with no gaps once streaming.
- Throughput: STAGES=4, random payloads, both sides always ready, 100 beats -> all 100 received within 104 cycles in order; in_ready stays 1 throughout.
- Random stall: random in_valid and out_ready at 50% each for 10k cycles -> scoreboard matches; occupancy always equals the model count and never exceeds 8.
- Flush: STAGES=2, occupancy=3, pulse rsp_flush for one cycle with in_valid=1 -> no transfer in that cycle; occupancy=0, idle follows in_valid, and the next beat emerges after 2 cycles.
- Reset mid-operation: assert rstn low while occupancy=2 -> out_valid=0 and occupancy=0 immediately; in_ready=1 after release. STAGES=0 run: outputs mirror inputs in the same cycle.
